// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external 3-flag magnitude comparator.
// Optional flag sanity check enabled by defining SAR_FLAG_CHECK_EN.
module sar_search_ctrl #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         cmp_aeb,
   input  logic         cmp_agb,
   input  logic         cmp_alb,
   output logic [W-1:0] trial,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         found,
   output logic         flag_err
);

   localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
   localparam logic [KW-1:0] K_MSB = KW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_VERIFY,
      ST_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_trial;
   logic [W-1:0]    r_acc;
   logic [KW-1:0]   r_k;
   logic [W-1:0]    r_result;
   logic            r_found;

   logic            w_flag_bad;
   logic            w_keep;
   logic            w_active;
   logic [W-1:0]    w_one_k;
   logic [W-1:0]    w_acc_nxt;
   logic [W-1:0]    w_trial_nxt;

`ifdef SAR_FLAG_CHECK_EN
   logic            r_flag_err;

   assign w_flag_bad = !$onehot({cmp_aeb, cmp_agb, cmp_alb});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flag_err <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_flag_err <= 1'b0;
      end else if (w_active && w_flag_bad) begin
         r_flag_err <= 1'b1;
      end
   end

   assign flag_err = r_flag_err;
`else
   assign w_flag_bad = 1'b0;
   assign flag_err   = 1'b0;
`endif

   // Bit k survives on "less than", or when the comparator asserts nothing at all.
   assign w_keep      = (cmp_alb & ~cmp_agb) | ~(cmp_agb | cmp_alb);
   assign w_active    = (r_state == ST_SEARCH) || (r_state == ST_VERIFY);
   assign w_one_k     = W'(1) << r_k;
   assign w_acc_nxt   = w_keep ? r_trial : r_acc;
   assign w_trial_nxt = (r_k == '0) ? w_acc_nxt : (w_acc_nxt | (w_one_k >> 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (w_flag_bad || cmp_aeb) begin
               w_state_nxt = ST_DONE;
            end else if (r_k == '0) begin
               w_state_nxt = ST_VERIFY;
            end
         end
         ST_VERIFY: w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_SEARCH, ST_VERIFY: busy = 1'b1;
         ST_DONE:              done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_trial  <= '0;
         r_acc    <= '0;
         r_k      <= K_MSB;
         r_result <= '0;
         r_found  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_acc    <= '0;
                  r_k      <= K_MSB;
                  r_trial  <= W'(1) << K_MSB;
                  r_result <= '0;
                  r_found  <= 1'b0;
               end
            end
            ST_SEARCH: begin
               if (w_flag_bad) begin
                  r_result <= r_acc;
                  r_found  <= 1'b0;
               end else if (cmp_aeb) begin
                  r_result <= r_trial;
                  r_found  <= 1'b1;
               end else begin
                  r_acc   <= w_acc_nxt;
                  r_trial <= w_trial_nxt;
                  if (r_k != '0) begin
                     r_k <= r_k - 1'b1;
                  end
               end
            end
            ST_VERIFY: begin
               r_result <= r_acc;
               r_found  <= cmp_aeb & ~w_flag_bad;
            end
            default: ;
         endcase
      end
   end

   assign trial  = r_trial;
   assign result = r_result;
   assign found  = r_found;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl (W=4) with a behavioural comparator on trial vs a 5-bit target.
// Flag-error steps build only when SAR_FLAG_CHECK_EN is defined.
module tb_sar_search_ctrl;

   typedef logic [3:0] tv_t [6];

   logic       clk;
   logic       reset;
   logic       start;
   logic       cmp_aeb;
   logic       cmp_agb;
   logic       cmp_alb;
   logic [3:0] trial;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       found;
   logic       flag_err;

   logic [4:0] target;
   logic       ovr;
   logic [2:0] ovr_flags;

   int unsigned vectors;
   int unsigned miscompares;

   sar_search_ctrl #(.W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .cmp_aeb  (cmp_aeb),
      .cmp_agb  (cmp_agb),
      .cmp_alb  (cmp_alb),
      .trial    (trial),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .found    (found),
      .flag_err (flag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (ovr) begin
         {cmp_aeb, cmp_agb, cmp_alb} = ovr_flags;
      end else begin
         cmp_aeb = ({1'b0, trial} == target);
         cmp_agb = ({1'b0, trial} >  target);
         cmp_alb = ({1'b0, trial} <  target);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int unsigned guard;
      guard = 0;
      while (done !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   task automatic run_search(input string tag, input logic [4:0] tgt, input tv_t et,
                             input int unsigned exp_n, input logic [3:0] exp_res,
                             input logic exp_found);
      int unsigned n;
      @(negedge clk);
      target = tgt;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 12) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         if (n < 6) chk({tag, "_trial"}, {28'd0, trial}, {28'd0, et[n]});
         n++;
         @(negedge clk);
      end
      chk({tag, "_done"},   {31'd0, done},   32'd1);
      chk({tag, "_cycles"}, n,               exp_n);
      chk({tag, "_result"}, {28'd0, result}, {28'd0, exp_res});
      chk({tag, "_found"},  {31'd0, found},  {31'd0, exp_found});
      chk({tag, "_nbusy"},  {31'd0, busy},   32'd0);
      @(negedge clk);
      chk({tag, "_pulse"},  {31'd0, done},   32'd0);
      chk({tag, "_hold"},   {28'd0, result}, {28'd0, exp_res});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      start       = 1'b0;
      target      = 5'd0;
      ovr         = 1'b0;
      ovr_flags   = 3'b000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_trial",  {28'd0, trial},  32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_result", {28'd0, result}, 32'd0);
      chk("rst_found",  {31'd0, found},  32'd0);
      chk("rst_ferr",   {31'd0, flag_err}, 32'd0);

      run_search("t9",  5'd9,  '{4'd8, 4'd12, 4'd10, 4'd9,  4'd0, 4'd0}, 4, 4'd9,  1'b1);
      chk("t9_trial_held", {28'd0, trial}, 32'd9);
      run_search("t8",  5'd8,  '{4'd8, 4'd0,  4'd0,  4'd0,  4'd0, 4'd0}, 1, 4'd8,  1'b1);
      run_search("t0",  5'd0,  '{4'd8, 4'd4,  4'd2,  4'd1,  4'd0, 4'd0}, 5, 4'd0,  1'b1);
      run_search("t20", 5'd20, '{4'd8, 4'd12, 4'd14, 4'd15, 4'd15, 4'd0}, 5, 4'd15, 1'b0);
      run_search("t7",  5'd7,  '{4'd8, 4'd4,  4'd6,  4'd7,  4'd0, 4'd0}, 4, 4'd7,  1'b1);

      // start held into SEARCH is ignored; reset on the second SEARCH cycle aborts at once
      @(negedge clk);
      target = 5'd9;
      start  = 1'b1;
      @(negedge clk);
      chk("ign_trial1", {28'd0, trial}, 32'd8);
      @(negedge clk);
      start = 1'b0;
      chk("ign_trial2", {28'd0, trial}, 32'd12);
      chk("ign_busy",   {31'd0, busy},  32'd1);
      reset = 1'b1;
      #1;
      chk("abort_trial",  {28'd0, trial},  32'd0);
      chk("abort_busy",   {31'd0, busy},   32'd0);
      chk("abort_done",   {31'd0, done},   32'd0);
      chk("abort_result", {28'd0, result}, 32'd0);
      chk("abort_found",  {31'd0, found},  32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_nodone", {31'd0, done}, 32'd0);
         chk("abort_idle",   {31'd0, busy}, 32'd0);
      end

`ifdef SAR_FLAG_CHECK_EN
      @(negedge clk);
      target = 5'd9;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ferr_trial1", {28'd0, trial}, 32'd8);
      @(negedge clk);
      chk("ferr_trial2", {28'd0, trial}, 32'd12);
      ovr       = 1'b1;
      ovr_flags = 3'b110;
      @(negedge clk);
      ovr = 1'b0;
      chk("ferr_done",   {31'd0, done},     32'd1);
      chk("ferr_flag",   {31'd0, flag_err}, 32'd1);
      chk("ferr_found",  {31'd0, found},    32'd0);
      chk("ferr_result", {28'd0, result},   32'd8);
      @(negedge clk);
      chk("ferr_sticky", {31'd0, flag_err}, 32'd1);
      target = 5'd8;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ferr_clear",  {31'd0, flag_err}, 32'd0);
      wait_done("ferr_next");
      chk("ferr_next_result", {28'd0, result}, 32'd8);
`else
      // aeb outranks agb when both assert
      @(negedge clk);
      target = 5'd9;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("prio_trial2", {28'd0, trial}, 32'd12);
      ovr       = 1'b1;
      ovr_flags = 3'b110;
      @(negedge clk);
      ovr = 1'b0;
      chk("prio_done",   {31'd0, done},     32'd1);
      chk("prio_result", {28'd0, result},   32'd12);
      chk("prio_found",  {31'd0, found},    32'd1);
      chk("prio_ferr",   {31'd0, flag_err}, 32'd0);
      // no flag at all counts as "less than"
      @(negedge clk);
      target = 5'd0;
      start  = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      ovr       = 1'b1;
      ovr_flags = 3'b000;
      @(negedge clk);
      ovr = 1'b0;
      chk("noflag_trial", {28'd0, trial}, 32'd12);
      wait_done("noflag");
      chk("noflag_result", {28'd0, result}, 32'd8);
      chk("noflag_found",  {31'd0, found},  32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
